pwlcm_iter: RTL and testbench

- Parametrised, multi-iteration piecewise-linear chaotic map (PWLCM) engine.
- Implements all four segments in unsigned fixed point: x in [0,1) as X/2^W, control p in (0,0.5) as P/2^W.
- Runs n_iter iterations per start, feeding each result back internally, and emits every x_k with a valid strobe.
- Serves as the keystream/state generator in the chaotic-cipher datapath.

---
 rtl/pwlcm_pkg.sv | 31 +++
 rtl/pwlcm_seq_div.sv | 72 +++++++
 rtl/pwlcm_iter.sv | 157 +++++++++++++++
 tb/tb_pwlcm_iter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pwlcm_pkg.sv
// Shared types and constants for the piecewise-linear chaotic map engine.
package pwlcm_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Which linear piece of the (mirrored) map applies.
    typedef enum logic {
        SEG_LO = 1'b0,
        SEG_HI = 1'b1
    } seg_t;

    // H = 2^(w-1) is one half, ONE = 2^w is unity, in w-bit fixed point.
    function automatic logic [63:0] pwlcm_h(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] pwlcm_one(input int unsigned w);
        return 64'd1 << w;
    endfunction

    localparam int unsigned PWLCM_W_DEF   = 32;
    localparam logic [63:0] PWLCM_H_DEF   = pwlcm_h(PWLCM_W_DEF);
    localparam logic [63:0] PWLCM_ONE_DEF = pwlcm_one(PWLCM_W_DEF);

endpackage

// File: rtl/pwlcm_seq_div.sv
// Restoring divider: q = floor(num * 2^W / den), one quotient bit per cycle,
// fixed W-cycle latency. Requires num <= den and den != 0.
module pwlcm_seq_div
    import pwlcm_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W:0]   num,
    input  logic [W:0]   den,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W:0]    rem_q, rem_d;
    logic [W:0]    den_q, den_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W+1:0]  rem_sh;
    logic [W+1:0]  trial;

    // One restoring step per cycle: shift remainder, subtract if it fits.
    always_comb begin
        rem_d  = rem_q;
        den_d  = den_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        rem_sh = {rem_q, 1'b0};
        trial  = rem_sh - {1'b0, den_q};
        if (load) begin
            rem_d = num;
            den_d = den;
            quo_d = '0;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            if (rem_sh >= {1'b0, den_q}) begin
                rem_d = trial[W:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[W:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            den_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            den_q <= den_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    // done marks the cycle computing the last bit; q is final from the next cycle.
    assign q    = quo_q;
    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/pwlcm_iter.sv
// Multi-iteration PWLCM engine: mirror/segment select, sequential division,
// saturation at X = H, internal feedback of each iterate.
module pwlcm_iter
    import pwlcm_pkg::*;
#(
    parameter int W      = 32,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W-1:0]      x0,
    input  logic [W-2:0]      p,
    input  logic [ITER_W-1:0] n_iter,
    output logic              busy,
    output logic [W-1:0]      xn,
    output logic              xn_valid,
    output logic              done,
    output logic              err
);

    localparam logic [W:0] H_C   = (W+1)'(pwlcm_h(W));
    localparam logic [W:0] ONE_C = (W+1)'(pwlcm_one(W));

    state_t            state_q, state_d;
    logic [W-1:0]      x_q, x_d;
    logic [W-2:0]      p_q, p_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic [W-1:0]      xn_q, xn_d;
    logic              xn_valid_q, xn_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [W:0]   x_ext, xm, p_ext, num_c, den_c;
    seg_t         seg_c;
    logic         sat_c;
    logic         div_load, div_busy, div_done;
    logic [W-1:0] div_q;
    logic [W-1:0] res_c;

    // Mirror about one half, pick the segment, form numerator/denominator.
    always_comb begin
        x_ext = {1'b0, x_q};
        p_ext = {2'b00, p_q};
        xm    = x_q[W-1] ? (ONE_C - x_ext) : x_ext;
        seg_c = (xm < p_ext) ? SEG_LO : SEG_HI;
        if (seg_c == SEG_LO) begin
            num_c = xm;
            den_c = p_ext;
        end else begin
            num_c = xm - p_ext;
            den_c = H_C - p_ext;
        end
        // N == D only when the mirrored value is exactly H.
        sat_c = (num_c == den_c);
        res_c = sat_q ? '1 : div_q;
    end

    pwlcm_seq_div #(.W(W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (div_load),
        .num   (num_c),
        .den   (den_c),
        .q     (div_q),
        .busy  (div_busy),
        .done  (div_done)
    );

    // Controller: accept a run, iterate PREP -> DIV -> OUT until the count expires.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        xn_d       = xn_q;
        xn_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        div_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (p == '0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (n_iter == '0) begin
                        done_d = 1'b1;
                    end else begin
                        x_d     = x0;
                        p_d     = p;
                        cnt_d   = n_iter;
                        state_d = PREP;
                    end
                end
            end
            PREP: begin
                div_load = 1'b1;
                sat_d    = sat_c;
                state_d  = DIV;
            end
            DIV: begin
                // Divider is always busy on entry; the idle check is only a safety exit.
                if (div_done || !div_busy) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                xn_d       = res_c;
                xn_valid_d = 1'b1;
                x_d        = res_c;
                cnt_d      = cnt_q - ITER_W'(1);
                if (cnt_q == ITER_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = PREP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any run silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            xn_q       <= '0;
            xn_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            xn_q       <= xn_d;
            xn_valid_q <= xn_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign xn       = xn_q;
    assign xn_valid = xn_valid_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pwlcm_iter.sv
// Directed bench for pwlcm_iter with hand-computed iterates and strobe timing.
module tb_pwlcm_iter;

    localparam int W      = 32;
    localparam int ITER_W = 16;
    localparam int TMO    = 200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [W-1:0]      x0 = '0;
    logic [W-2:0]      p = '0;
    logic [ITER_W-1:0] n_iter = '0;
    logic              busy;
    logic [W-1:0]      xn;
    logic              xn_valid;
    logic              done;
    logic              err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    pwlcm_iter #(.W(W), .ITER_W(ITER_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x0       (x0),
        .p        (p),
        .n_iter   (n_iter),
        .busy     (busy),
        .xn       (xn),
        .xn_valid (xn_valid),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge; cyc counts edges after the sampling edge.
    task automatic start_run(input logic [W-1:0] x, input logic [W-2:0] pp,
                             input logic [ITER_W-1:0] n);
        @(negedge clk);
        x0     = x;
        p      = pp;
        n_iter = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 0;
    endtask

    // Wait for the next xn_valid and check value, arrival edge and done.
    task automatic wait_valid(input string tag, input logic [W-1:0] exp_xn,
                              input int exp_cyc, input logic exp_done);
        int k;
        k = 0;
        while (k < TMO) begin
            @(negedge clk);
            cyc++;
            k++;
            if (xn_valid) break;
        end
        chk({tag, "_seen"}, {63'd0, xn_valid}, 64'd1);
        chk({tag, "_xn"}, {32'd0, xn}, {32'd0, exp_xn});
        chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    endtask

    task automatic single(input string tag, input logic [W-1:0] x, input logic [W-2:0] pp,
                          input logic [W-1:0] exp_xn);
        start_run(x, pp, 16'd1);
        wait_valid(tag, exp_xn, 34, 1'b1);
    endtask

    initial begin
        int strobes;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_xn", {32'd0, xn}, 64'd0);
        chk("rst_strobes", {61'd0, xn_valid, done, err}, 64'd0);
        rst_n = 1'b1;

        // Three iterations: segment 1, saturation at H, then mirror of all-ones.
        start_run(32'h2000_0000, 31'h4000_0000, 16'd3);
        chk("run_busy", {63'd0, busy}, 64'd1);
        wait_valid("it1", 32'h8000_0000, 34, 1'b0);
        wait_valid("it2", 32'hFFFF_FFFF, 68, 1'b0);
        wait_valid("it3", 32'h0000_0004, 102, 1'b1);
        @(negedge clk);
        chk("it3_idle", {62'd0, busy, xn_valid}, 64'd0);
        chk("it3_hold", {32'd0, xn}, 64'h0000_0004);

        single("seg2", 32'h6000_0000, 31'h4000_0000, 32'h8000_0000);
        single("mirror", 32'hA000_0000, 31'h4000_0000, 32'h8000_0000);
        single("zero", 32'h0000_0000, 31'h4000_0000, 32'h0000_0000);
        single("seg1_3q", 32'h3000_0000, 31'h4000_0000, 32'hC000_0000);
        single("seg2_q", 32'h5000_0000, 31'h4000_0000, 32'h4000_0000);
        single("third", 32'h1000_0000, 31'h3000_0000, 32'h5555_5555);

        // p == 0: err and done on the next cycle, nothing else.
        start_run(32'h1234_5678, 31'h0, 16'd4);
        chk("perr_flags", {61'd0, err, done, xn_valid}, 64'd6);
        chk("perr_busy", {63'd0, busy}, 64'd0);
        chk("perr_xn", {32'd0, xn}, 64'h5555_5555);
        @(negedge clk);
        chk("perr_pulse", {62'd0, err, done}, 64'd0);

        // n_iter == 0: done only.
        start_run(32'h1234_5678, 31'h4000_0000, 16'd0);
        chk("nzero_flags", {61'd0, err, done, xn_valid}, 64'd2);
        chk("nzero_busy", {63'd0, busy}, 64'd0);

        // A start while busy must be ignored.
        start_run(32'h2000_0000, 31'h4000_0000, 16'd1);
        repeat (4) @(negedge clk);
        cyc += 4;
        x0     = 32'hFFFF_FFFF;
        n_iter = 16'd3;
        start  = 1'b1;
        @(negedge clk);
        cyc++;
        start  = 1'b0;
        wait_valid("ignore", 32'h8000_0000, 34, 1'b1);
        @(negedge clk);
        chk("ignore_idle", {63'd0, busy}, 64'd0);

        // Reset during the divide phase aborts the run without strobes.
        start_run(32'h6000_0000, 31'h4000_0000, 16'd1);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_xn", {32'd0, xn}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xn_valid || done || err) strobes++;
        end
        chk("abort_quiet", 64'(strobes), 64'd0);
        single("after_rst", 32'hA000_0000, 31'h4000_0000, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
